hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage core.
- Detects data hazards in decode and produces the registered forwarding selects that travel with the ID/EX register into execute.
- Drives `keep`/`nop` on the execute stage and hold/flush on the PC and IF/ID registers.
- Sequences load-use stalls, data-memory wait stalls and branch/CSR redirect flushes with one FSM.

---
 rtl/hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: registered forwarding selects plus a RUN/LSTALL/MWAIT/FLUSH FSM.
// Optional macro HAZARD_PERF_CNT_EN adds live stall/flush counters; when it is undefined the counters are tied to 0.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_wreg,
    input  logic        ex_regwrite,
    input  logic        ex_is_load,
    input  logic [4:0]  mem_wreg,
    input  logic        mem_regwrite,
    input  logic        mem_is_load,
    input  logic [4:0]  wb_wreg,
    input  logic        wb_regwrite,
    input  logic        branch_taken,
    input  logic        csr_redirect,
    input  logic        dmem_busy,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        ex_keep,
    output logic        ex_nop,
    output logic [1:0]  fwd_ex_pyc,
    output logic [1:0]  fwd_mem_pyc,
    output logic [1:0]  fwd_load_pyc,
    output logic [1:0]  fwd_wb_pyc,
    output logic [1:0]  state_o,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, MWAIT = 2'd2, FLUSH = 2'd3} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, nxt_state;
    logic [2:0] cnt, nxt_cnt;
    logic [1:0] m_ex, m_mem, m_wb;
    logic       load_use, run_eval, allow_redirect;
    logic       hold, flush, keep, nop;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic src_match(input logic used, input logic regwrite,
                                       input logic [4:0] wreg, input logic [4:0] src);
        return id_valid & used & regwrite & (wreg == src) & (wreg != 5'd0);
    endfunction

    always_comb begin
        m_ex[1]  = src_match(id_use_rs1, ex_regwrite,  ex_wreg,  id_rs1);
        m_ex[0]  = src_match(id_use_rs2, ex_regwrite,  ex_wreg,  id_rs2);
        m_mem[1] = src_match(id_use_rs1, mem_regwrite, mem_wreg, id_rs1);
        m_mem[0] = src_match(id_use_rs2, mem_regwrite, mem_wreg, id_rs2);
        m_wb[1]  = src_match(id_use_rs1, wb_regwrite,  wb_wreg,  id_rs1);
        m_wb[0]  = src_match(id_use_rs2, wb_regwrite,  wb_wreg,  id_rs2);
        load_use = (|m_ex) & ex_is_load;
    end

    // Outputs are Mealy: the cycle that decides a transition already drives the target's controls.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        nxt_state      = state;
        nxt_cnt        = cnt;
        hold           = 1'b0;
        flush          = 1'b0;
        keep           = 1'b0;
        nop            = 1'b0;
        run_eval       = 1'b0;
        allow_redirect = 1'b1;
        case (state)
            RUN, LSTALL: run_eval = 1'b1;
            MWAIT: begin
                if (dmem_busy) begin
                    hold = 1'b1;
                    keep = 1'b1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt == 3'd0) begin
                    // Last FLUSH cycle behaves as RUN, but redirects here still come from squashed slots.
                    run_eval       = 1'b1;
                    allow_redirect = 1'b0;
                end else begin
                    flush = 1'b1;
                    nop   = 1'b1;
                    if (dmem_busy) begin
                        hold = 1'b1;
                        keep = 1'b1;
                    end else begin
                        nxt_cnt = cnt - 3'd1;
                    end
                end
            end
            default: run_eval = 1'b1;
        endcase

        if (run_eval) begin
            if (dmem_busy) begin
                nxt_state = MWAIT;
                hold      = 1'b1;
                keep      = 1'b1;
            end else if (allow_redirect && (branch_taken || csr_redirect)) begin
                nxt_state = FLUSH;
                nxt_cnt   = FLUSH_LOAD;
                flush     = 1'b1;
                nop       = 1'b1;
            end else if (load_use) begin
                nxt_state = LSTALL;
                hold      = 1'b1;
                nop       = 1'b1;
            end else begin
                nxt_state = RUN;
            end
        end
    end

    // Reset forces the controls low at once rather than waiting for the state register.
    always_comb begin
        pc_hold    = rst & hold;
        ifid_hold  = rst & hold;
        ifid_flush = rst & flush;
        ex_keep    = rst & keep;
        ex_nop     = rst & nop & ~keep;
        state_o    = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            cnt          <= 3'd0;
            fwd_ex_pyc   <= 2'b00;
            fwd_mem_pyc  <= 2'b00;
            fwd_load_pyc <= 2'b00;
            fwd_wb_pyc   <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= nxt_state;
            cnt   <= nxt_cnt;
            if (keep) begin
                fwd_ex_pyc <= fwd_ex_pyc;
            end else if (nop) begin
                fwd_ex_pyc   <= 2'b00;
                fwd_mem_pyc  <= 2'b00;
                fwd_load_pyc <= 2'b00;
                fwd_wb_pyc   <= 2'b00;
            end else begin
                fwd_ex_pyc   <= m_ex;
                fwd_load_pyc <= ~m_ex & m_mem & {2{mem_is_load}};
                fwd_mem_pyc  <= ~m_ex & m_mem & {2{~mem_is_load}};
                fwd_wb_pyc   <= ~m_ex & ~m_mem & m_wb;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (state == LSTALL || state == MWAIT) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (nxt_state == FLUSH && state != FLUSH) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES = 2): forwarding, load-use, MWAIT, FLUSH, x0 and reset cases.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid, id_use_rs1, id_use_rs2;
    logic [4:0]  id_rs1, id_rs2, ex_wreg, mem_wreg, wb_wreg;
    logic        ex_regwrite, ex_is_load, mem_regwrite, mem_is_load, wb_regwrite;
    logic        branch_taken, csr_redirect, dmem_busy;
    logic        pc_hold, ifid_hold, ifid_flush, ex_keep, ex_nop;
    logic [1:0]  fwd_ex_pyc, fwd_mem_pyc, fwd_load_pyc, fwd_wb_pyc, state_o;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load),
        .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken), .csr_redirect(csr_redirect), .dmem_busy(dmem_busy),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .ex_keep(ex_keep), .ex_nop(ex_nop),
        .fwd_ex_pyc(fwd_ex_pyc), .fwd_mem_pyc(fwd_mem_pyc),
        .fwd_load_pyc(fwd_load_pyc), .fwd_wb_pyc(fwd_wb_pyc),
        .state_o(state_o),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0;
        ex_wreg = 5'd0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
        mem_wreg = 5'd0; mem_regwrite = 1'b0; mem_is_load = 1'b0;
        wb_wreg = 5'd0; wb_regwrite = 1'b0;
        branch_taken = 1'b0; csr_redirect = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic decode(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    endtask

    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        check({tag, ".ctrl"}, {27'd0, pc_hold, ifid_hold, ifid_flush, ex_keep, ex_nop}, {27'd0, exp});
    endtask

    task automatic check_fwd(input string tag, input logic [1:0] e_ex, input logic [1:0] e_mem,
                             input logic [1:0] e_load, input logic [1:0] e_wb);
        check({tag, ".fwd"}, {24'd0, fwd_ex_pyc, fwd_mem_pyc, fwd_load_pyc, fwd_wb_pyc},
              {24'd0, e_ex, e_mem, e_load, e_wb});
    endtask

    // ctrl vector order: {pc_hold, ifid_hold, ifid_flush, ex_keep, ex_nop}
    initial begin
        clr_in();
        #3;
        check("reset.state", 32'(state_o), 32'd0);
        check_ctrl("reset", 5'b00000);
        check_fwd("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        #9 rst = 1'b1;
        tick();

        // add x5 in EX, decode sub x6,x5,x7
        clr_in(); decode(5'd5, 5'd7, 1'b1, 1'b1);
        ex_wreg = 5'd5; ex_regwrite = 1'b1;
        #1 check_ctrl("exfwd", 5'b00000);
        tick();
        check_fwd("exfwd", 2'b10, 2'b00, 2'b00, 2'b00);
        check("exfwd.state", 32'(state_o), 32'd0);

        // lw x5 in EX, decode add x6,x5,x5
        clr_in(); decode(5'd5, 5'd5, 1'b1, 1'b1);
        ex_wreg = 5'd5; ex_regwrite = 1'b1; ex_is_load = 1'b1;
        #1 check_ctrl("lu.stall", 5'b11001);
        tick();
        check("lu.state1", 32'(state_o), 32'd1);
        check_fwd("lu.bubble", 2'b00, 2'b00, 2'b00, 2'b00);
        ex_regwrite = 1'b0; ex_is_load = 1'b0; ex_wreg = 5'd0;
        mem_wreg = 5'd5; mem_regwrite = 1'b1; mem_is_load = 1'b1;
        #1 check_ctrl("lu.release", 5'b00000);
        tick();
        check_fwd("lu.load", 2'b00, 2'b00, 2'b11, 2'b00);
        check("lu.state2", 32'(state_o), 32'd0);

        // taken branch, second branch_taken during FLUSH is ignored
        clr_in(); branch_taken = 1'b1;
        #1 check_ctrl("br.c0", 5'b00101);
        tick();
        check("br.state1", 32'(state_o), 32'd3);
        #1 check_ctrl("br.c1", 5'b00101);
        tick();
        #1 check_ctrl("br.c2", 5'b00000);
        tick();
        check("br.state3", 32'(state_o), 32'd0);
        branch_taken = 1'b0;

        // dmem_busy for 3 cycles over a load-use hazard
        clr_in(); decode(5'd5, 5'd0, 1'b1, 1'b0);
        ex_wreg = 5'd5; ex_regwrite = 1'b1; ex_is_load = 1'b1; dmem_busy = 1'b1;
        #1 check_ctrl("mw.c0", 5'b11010);
        tick();
        check("mw.state", 32'(state_o), 32'd2);
        #1 check_ctrl("mw.c1", 5'b11010);
        tick();
        #1 check_ctrl("mw.c2", 5'b11010);
        tick();
        dmem_busy = 1'b0;
        #1 check_ctrl("mw.exit", 5'b11001);
        tick();
        check("mw.lstall", 32'(state_o), 32'd1);
        ex_regwrite = 1'b0; ex_is_load = 1'b0; ex_wreg = 5'd0;
        mem_wreg = 5'd5; mem_regwrite = 1'b1; mem_is_load = 1'b1;
        #1 check_ctrl("mw.release", 5'b00000);
        tick();
        check_fwd("mw.load", 2'b00, 2'b00, 2'b10, 2'b00);

        // x0 never forwards or stalls
        clr_in(); decode(5'd0, 5'd0, 1'b1, 1'b1);
        ex_wreg = 5'd0; ex_regwrite = 1'b1; ex_is_load = 1'b1;
        #1 check_ctrl("x0", 5'b00000);
        tick();
        check_fwd("x0", 2'b00, 2'b00, 2'b00, 2'b00);

        // mem beats wb on rs2; wb alone on rs1
        clr_in(); decode(5'd12, 5'd9, 1'b1, 1'b1);
        mem_wreg = 5'd9; mem_regwrite = 1'b1;
        wb_wreg = 5'd9; wb_regwrite = 1'b1;
        tick();
        check_fwd("memwb", 2'b00, 2'b01, 2'b00, 2'b00);
        wb_wreg = 5'd12;
        tick();
        check_fwd("wbrs1", 2'b00, 2'b01, 2'b00, 2'b10);
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        tick();
        check_fwd("nouse", 2'b00, 2'b00, 2'b00, 2'b00);

`ifdef HAZARD_PERF_CNT_EN
        check("perf.stall", perf_stall_cnt, 32'd5);
        check("perf.flush", perf_flush_cnt, 32'd1);
`else
        check("perf.stall", perf_stall_cnt, 32'd0);
        check("perf.flush", perf_flush_cnt, 32'd0);
`endif

        // reset asserted mid-flush (counter = 1)
        clr_in(); branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        #1 check("rf.state", 32'(state_o), 32'd3);
        check_ctrl("rf.pre", 5'b00101);
        rst = 1'b0;
        #1 check("rf.rstate", 32'(state_o), 32'd0);
        check_ctrl("rf.rst", 5'b00000);
        check("rf.pstall", perf_stall_cnt, 32'd0);
        check("rf.pflush", perf_flush_cnt, 32'd0);
        #1 rst = 1'b1;
        tick();
        check("rf.after", 32'(state_o), 32'd0);
        check_ctrl("rf.after", 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
